// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   NOP_INST_DEF   instruction returned on miss, dropped refill or reset
//   ST_IDLE/FILL   controller state encoding
//   idx_lsb/tag_lsb  bit offsets of the index and tag fields in a fetch address
package icache_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Byte offset bits [1:0] are ignored; the word-in-line field starts at bit 2.
    localparam int WORD_LSB = 2;

    function automatic int idx_lsb(input int line_words);
        return WORD_LSB + $clog2(line_words);
    endfunction

    function automatic int tag_lsb(input int sets, input int line_words);
        return idx_lsb(line_words) + $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: SETS lines x LINE_WORDS words x 32 bits.
//   clk        clock
//   we_i       write one word (refill beat)
//   widx_i     line index of the write
//   wword_i    word within the line of the write
//   wdata_i    write data
//   ridx_i     line index of the read
//   rword_i    word within the line of the read
//   rdata_o    read data, combinational
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int IB         = $clog2(SETS),
    parameter int WB         = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [IB-1:0] widx_i,
    input  logic [WB-1:0] wword_i,
    input  logic [31:0]   wdata_i,
    input  logic [IB-1:0] ridx_i,
    input  logic [WB-1:0] rword_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [SETS*LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[{widx_i, wword_i}] <= wdata_i;
    end

    assign rdata_o = mem_q[{ridx_i, rword_i}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache between the IF stage and the bus controller.
// Lookup is combinational (hit returns the instruction in the same cycle); a
// miss runs an in-order line refill through the bus controller.
//   clk, rst_n                 clock, synchronous active-low reset
//   if_req_Icache_i/if_addr_i  fetch request and word-aligned byte address
//   fc_stall_Icache_i          no new refill may start
//   fc_jump_flag_Icache_i      redirect; a refill in flight is delivered as NOP
//   Icache_hit_o/Icache_inst_o hit flag and fetched instruction
//   Icache_req_bc_o/addr_bc_o  refill request (level) and line-aligned address
//   bc_Icache_valid_i/data_i   refill beat
//   bc_Icache_ready_i          refill complete, coincides with the last beat
module icache_dm
    import icache_pkg::*;
#(
    parameter int          SETS       = 64,
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_Icache_i,
    input  logic [31:0] if_addr_i,
    input  logic        fc_stall_Icache_i,
    input  logic        fc_jump_flag_Icache_i,
    output logic        Icache_hit_o,
    output logic [31:0] Icache_inst_o,
    output logic        Icache_req_bc_o,
    output logic [31:0] Icache_addr_bc_o,
    input  logic        bc_Icache_valid_i,
    input  logic [31:0] bc_Icache_data_i,
    input  logic        bc_Icache_ready_i
);

    localparam int WB   = $clog2(LINE_WORDS);
    localparam int IB   = $clog2(SETS);
    localparam int ILSB = idx_lsb(LINE_WORDS);
    localparam int TLSB = tag_lsb(SETS, LINE_WORDS);
    localparam int TW   = 32 - TLSB;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << ILSB) - 32'd1);

    logic [0:0]      state_q, state_d;
    logic [WB-1:0]   cnt_q, cnt_d;
    logic            wrap_q, wrap_d;      // all beats received; extras are dropped
    logic [31:0]     fill_addr_q, fill_addr_d;
    logic [WB-1:0]   req_word_q, req_word_d;
    logic            drop_q, drop_d;
    logic            req_bc_q, req_bc_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic [TW-1:0]   tag_q [SETS];

    logic [WB-1:0] a_word;
    logic [IB-1:0] a_idx, fill_idx, r_idx;
    logic [TW-1:0] a_tag, fill_tag;
    logic [WB-1:0] r_word;
    logic [31:0]   rdata;
    logic          lookup_hit, beat_ok, done, tag_we;
    logic          unused_addr_bits;

    assign a_word   = if_addr_i[WORD_LSB +: WB];
    assign a_idx    = if_addr_i[ILSB +: IB];
    assign a_tag    = if_addr_i[31:TLSB];
    assign fill_idx = fill_addr_q[ILSB +: IB];
    assign fill_tag = fill_addr_q[31:TLSB];
    assign unused_addr_bits = ^if_addr_i[1:0];

    assign lookup_hit = (state_q == ST_IDLE) && if_req_Icache_i && valid_q[a_idx]
                        && (tag_q[a_idx] == a_tag);
    assign beat_ok    = (state_q == ST_FILL) && bc_Icache_valid_i && !wrap_q;
    assign done       = (state_q == ST_FILL) && bc_Icache_valid_i && bc_Icache_ready_i;

    // During a refill the single read port serves the requested word so it can
    // be returned on the completion cycle.
    assign r_idx  = (state_q == ST_FILL) ? fill_idx   : a_idx;
    assign r_word = (state_q == ST_FILL) ? req_word_q : a_word;

    icache_data_ram #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_data (
        .clk     (clk),
        .we_i    (beat_ok && rst_n),
        .widx_i  (fill_idx),
        .wword_i (cnt_q),
        .wdata_i (bc_Icache_data_i),
        .ridx_i  (r_idx),
        .rword_i (r_word),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wrap_d      = wrap_q;
        fill_addr_d = fill_addr_q;
        req_word_d  = req_word_q;
        drop_d      = drop_q;
        req_bc_d    = req_bc_q;
        valid_d     = valid_q;
        tag_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req_Icache_i && !lookup_hit && !fc_stall_Icache_i) begin
                    state_d     = ST_FILL;
                    fill_addr_d = if_addr_i & LINE_MASK;
                    req_word_d  = a_word;
                    drop_d      = 1'b0;
                    cnt_d       = '0;
                    wrap_d      = 1'b0;
                    req_bc_d    = 1'b1;
                end
            end
            default: begin
                if (beat_ok) begin
                    cnt_d = cnt_q + WB'(1);
                    if (cnt_q == WB'(LINE_WORDS - 1)) wrap_d = 1'b1;
                end
                if (fc_jump_flag_Icache_i) drop_d = 1'b1;
                if (done) begin
                    state_d           = ST_IDLE;
                    req_bc_d          = 1'b0;
                    valid_d[fill_idx] = 1'b1;
                    tag_we            = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            fill_addr_q <= '0;
            req_word_q  <= '0;
            drop_q      <= 1'b0;
            req_bc_q    <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            fill_addr_q <= fill_addr_d;
            req_word_q  <= req_word_d;
            drop_q      <= drop_d;
            req_bc_q    <= req_bc_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we && rst_n) tag_q[fill_idx] <= fill_tag;
    end

    always_comb begin
        Icache_hit_o  = 1'b0;
        Icache_inst_o = NOP_INST;
        if (rst_n) begin
            if (state_q == ST_IDLE) begin
                Icache_hit_o = lookup_hit;
                if (lookup_hit) Icache_inst_o = rdata;
            end else if (done && !(drop_q || fc_jump_flag_Icache_i)) begin
                // Last beat is not in the array yet; forward it if it was the one asked for.
                Icache_inst_o = (beat_ok && cnt_q == req_word_q) ? bc_Icache_data_i : rdata;
            end
        end
    end

    assign Icache_req_bc_o  = req_bc_q;
    assign Icache_addr_bc_o = fill_addr_q;

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_Icache_i;
    logic [31:0] if_addr_i;
    logic        fc_stall_Icache_i;
    logic        fc_jump_flag_Icache_i;
    logic        Icache_hit_o;
    logic [31:0] Icache_inst_o;
    logic        Icache_req_bc_o;
    logic [31:0] Icache_addr_bc_o;
    logic        bc_Icache_valid_i;
    logic [31:0] bc_Icache_data_i;
    logic        bc_Icache_ready_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache_dm dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .if_req_Icache_i       (if_req_Icache_i),
        .if_addr_i             (if_addr_i),
        .fc_stall_Icache_i     (fc_stall_Icache_i),
        .fc_jump_flag_Icache_i (fc_jump_flag_Icache_i),
        .Icache_hit_o          (Icache_hit_o),
        .Icache_inst_o         (Icache_inst_o),
        .Icache_req_bc_o       (Icache_req_bc_o),
        .Icache_addr_bc_o      (Icache_addr_bc_o),
        .bc_Icache_valid_i     (bc_Icache_valid_i),
        .bc_Icache_data_i      (bc_Icache_data_i),
        .bc_Icache_ready_i     (bc_Icache_ready_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a miss; report hit on the request cycle and the bus request one cycle later.
    task automatic start_miss(input logic [31:0] addr, output logic h0,
                              output logic rb1, output logic [31:0] ab1);
        step();
        if_req_Icache_i = 1'b1;
        if_addr_i       = addr;
        @(negedge clk);
        h0 = Icache_hit_o;
        step();
        if_req_Icache_i = 1'b0;
        @(negedge clk);
        rb1 = Icache_req_bc_o;
        ab1 = Icache_addr_bc_o;
    endtask

    // Four beats d0..d0+3, ready with the last; optional jump pulse on beat jb.
    task automatic fill_line(input logic [31:0] d0, input int jb,
                             output logic [31:0] r_inst, output logic r_hit);
        for (int b = 0; b < 4; b++) begin
            step();
            bc_Icache_valid_i     = 1'b1;
            bc_Icache_data_i      = d0 + 32'(b);
            bc_Icache_ready_i     = (b == 3);
            fc_jump_flag_Icache_i = (b == jb);
            @(negedge clk);
        end
        r_inst = Icache_inst_o;
        r_hit  = Icache_hit_o;
        step();
        bc_Icache_valid_i     = 1'b0;
        bc_Icache_ready_i     = 1'b0;
        fc_jump_flag_Icache_i = 1'b0;
    endtask

    task automatic probe(input logic [31:0] addr, input logic stall,
                         output logic h, output logic [31:0] inst);
        step();
        if_req_Icache_i   = 1'b1;
        if_addr_i         = addr;
        fc_stall_Icache_i = stall;
        @(negedge clk);
        h    = Icache_hit_o;
        inst = Icache_inst_o;
        step();
        if_req_Icache_i   = 1'b0;
        fc_stall_Icache_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req_Icache_i = 1'b1;
        if_addr_i = 32'h100;
        fc_stall_Icache_i = 1'b0;
        fc_jump_flag_Icache_i = 1'b0;
        bc_Icache_valid_i = 1'b0;
        bc_Icache_data_i = '0;
        bc_Icache_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (Icache_hit_o !== 1'b0) begin errors++; $display("FAIL rst_hit got=%b exp=0", Icache_hit_o); end
        checks++; if (Icache_inst_o !== NOP) begin errors++; $display("FAIL rst_inst got=%h exp=%h", Icache_inst_o, NOP); end
        checks++; if (Icache_req_bc_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", Icache_req_bc_o); end
        checks++; if (Icache_addr_bc_o !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", Icache_addr_bc_o); end
        step();
        rst_n = 1'b1;
        if_req_Icache_i = 1'b0;
    endtask

    task automatic test_refill();
        logic h, rb; logic [31:0] ab, ri, inst;
        start_miss(32'h100, h, rb, ab);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL miss100_hit got=%b exp=0", h); end
        checks++; if (rb !== 1'b1) begin errors++; $display("FAIL miss100_req got=%b exp=1", rb); end
        checks++; if (ab !== 32'h100) begin errors++; $display("FAIL miss100_addr got=%h exp=100", ab); end
        fill_line(32'hA000_0000, -1, ri, h);
        checks++; if (ri !== 32'hA000_0000) begin errors++; $display("FAIL fill100_inst got=%h exp=a0000000", ri); end
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL fill100_hit got=%b exp=0", h); end
        checks++; if (Icache_req_bc_o !== 1'b0) begin errors++; $display("FAIL fill100_reqdrop got=%b exp=0", Icache_req_bc_o); end
        probe(32'h104, 1'b0, h, inst);
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL hit104 got=%b exp=1", h); end
        checks++; if (inst !== 32'hA000_0001) begin errors++; $display("FAIL hit104_inst got=%h exp=a0000001", inst); end
        probe(32'h10C, 1'b0, h, inst);
        checks++; if (inst !== 32'hA000_0003 || h !== 1'b1) begin errors++; $display("FAIL hit10c got=%b/%h exp=1/a0000003", h, inst); end
    endtask

    task automatic test_bypass();
        logic h, rb; logic [31:0] ab, ri, inst;
        start_miss(32'h21C, h, rb, ab);
        checks++; if (ab !== 32'h210) begin errors++; $display("FAIL miss21c_addr got=%h exp=210", ab); end
        fill_line(32'hB000_0000, -1, ri, h);
        checks++; if (ri !== 32'hB000_0003) begin errors++; $display("FAIL bypass_inst got=%h exp=b0000003", ri); end
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL bypass_hit got=%b exp=0", h); end
        probe(32'h21C, 1'b0, h, inst);
        checks++; if (h !== 1'b1 || inst !== 32'hB000_0003) begin errors++; $display("FAIL hit21c got=%b/%h exp=1/b0000003", h, inst); end
        probe(32'h214, 1'b0, h, inst);
        checks++; if (h !== 1'b1 || inst !== 32'hB000_0001) begin errors++; $display("FAIL hit214 got=%b/%h exp=1/b0000001", h, inst); end
    endtask

    task automatic test_jump();
        logic h, rb; logic [31:0] ab, ri, inst;
        start_miss(32'h300, h, rb, ab);
        fill_line(32'hC000_0000, 2, ri, h);
        checks++; if (ri !== NOP) begin errors++; $display("FAIL jump_inst got=%h exp=%h", ri, NOP); end
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL jump_hit got=%b exp=0", h); end
        probe(32'h300, 1'b0, h, inst);
        checks++; if (h !== 1'b1 || inst !== 32'hC000_0000) begin errors++; $display("FAIL hit300 got=%b/%h exp=1/c0000000", h, inst); end
    endtask

    task automatic test_stall();
        logic h; logic [31:0] ri;
        for (int i = 0; i < 3; i++) begin
            step();
            if_req_Icache_i = 1'b1; if_addr_i = 32'h400; fc_stall_Icache_i = 1'b1;
            @(negedge clk);
            checks++; if (Icache_req_bc_o !== 1'b0 || Icache_hit_o !== 1'b0 || Icache_inst_o !== NOP) begin
                errors++; $display("FAIL stall%0d got req=%b hit=%b inst=%h exp 0/0/%h", i, Icache_req_bc_o, Icache_hit_o, Icache_inst_o, NOP);
            end
        end
        step();
        fc_stall_Icache_i = 1'b0;
        @(negedge clk);
        step();
        if_req_Icache_i = 1'b0;
        @(negedge clk);
        checks++; if (Icache_req_bc_o !== 1'b1 || Icache_addr_bc_o !== 32'h400) begin
            errors++; $display("FAIL stall_release got req=%b addr=%h exp 1/400", Icache_req_bc_o, Icache_addr_bc_o);
        end
        fill_line(32'hD000_0000, -1, ri, h);
        checks++; if (ri !== 32'hD000_0000) begin errors++; $display("FAIL fill400_inst got=%h exp=d0000000", ri); end
    endtask

    task automatic test_reset_mid_fill();
        logic h, rb; logic [31:0] ab, ri;
        start_miss(32'h500, h, rb, ab);
        for (int b = 0; b < 2; b++) begin
            step();
            bc_Icache_valid_i = 1'b1; bc_Icache_data_i = 32'hEEEE_0000 + 32'(b);
            @(negedge clk);
        end
        step();
        bc_Icache_valid_i = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++; if (Icache_hit_o !== 1'b0 || Icache_inst_o !== NOP) begin errors++; $display("FAIL midrst_out got=%b/%h exp=0/%h", Icache_hit_o, Icache_inst_o, NOP); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (Icache_req_bc_o !== 1'b0 || Icache_addr_bc_o !== 32'h0) begin errors++; $display("FAIL midrst_req got=%b/%h exp=0/0", Icache_req_bc_o, Icache_addr_bc_o); end
        start_miss(32'h500, h, rb, ab);
        checks++; if (h !== 1'b0 || rb !== 1'b1 || ab !== 32'h500) begin errors++; $display("FAIL midrst_remiss got=%b/%b/%h exp=0/1/500", h, rb, ab); end
        fill_line(32'hE000_0000, -1, ri, h);
        checks++; if (ri !== 32'hE000_0000) begin errors++; $display("FAIL fill500_inst got=%h exp=e0000000", ri); end
    endtask

    task automatic test_conflict();
        logic h, rb; logic [31:0] ab, ri, inst;
        // Reset wiped 0x100; refilling it evicts 0x500 (same index).
        start_miss(32'h100, h, rb, ab);
        checks++; if (h !== 1'b0 || rb !== 1'b1) begin errors++; $display("FAIL conf_miss100 got=%b/%b exp=0/1", h, rb); end
        fill_line(32'hA100_0000, -1, ri, h);
        probe(32'h100, 1'b0, h, inst);
        checks++; if (h !== 1'b1 || inst !== 32'hA100_0000) begin errors++; $display("FAIL conf_hit100 got=%b/%h exp=1/a1000000", h, inst); end
        probe(32'h500, 1'b1, h, inst);
        checks++; if (h !== 1'b0 || inst !== NOP) begin errors++; $display("FAIL conf_evict500 got=%b/%h exp=0/%h", h, inst, NOP); end
        start_miss(32'h500, h, rb, ab);
        fill_line(32'hF000_0000, -1, ri, h);
        probe(32'h100, 1'b1, h, inst);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL conf_evict100 got=%b exp=0", h); end
        // Stray beat while idle must not touch the array.
        step();
        bc_Icache_valid_i = 1'b1; bc_Icache_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        step();
        bc_Icache_valid_i = 1'b0;
        probe(32'h500, 1'b0, h, inst);
        checks++; if (h !== 1'b1 || inst !== 32'hF000_0000) begin errors++; $display("FAIL stray_beat got=%b/%h exp=1/f0000000", h, inst); end
    endtask

    initial begin
        test_reset();
        test_refill();
        test_bypass();
        test_jump();
        test_stall();
        test_reset_mid_fill();
        test_conflict();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
